// File: rtl/hasti_bus_n.sv
// hasti_bus_n: one-master, NSLAVES-slave AHB-Lite interconnect.
// Address decode, data-phase response mux, two-cycle ERROR default slave,
// per-transfer stall watchdog and sticky error-capture status.
module hasti_bus_n #(
  parameter int NSLAVES = 3,
  parameter int XLEN    = 32,
  parameter logic [NSLAVES*XLEN-1:0] SLV_BASE = {32'h8000_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NSLAVES*XLEN-1:0] SLV_MASK = {32'hC000_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int TIMEOUT = 1024
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [XLEN-1:0]         m_haddr,
  input  logic [1:0]              m_htrans,
  output logic                    m_hready,
  output logic [XLEN-1:0]         m_hrdata,
  output logic                    m_hresp,
  output logic [NSLAVES-1:0]      s_hsel,
  output logic                    s_hready,
  input  logic [NSLAVES-1:0]      s_hreadyout,
  input  logic [NSLAVES*XLEN-1:0] s_hrdata,
  input  logic [NSLAVES-1:0]      s_hresp,
  input  logic                    err_clr,
  output logic                    err_valid,
  output logic [1:0]              err_cause,
  output logic [XLEN-1:0]         err_addr
);
  // A zero TIMEOUT still needs a 1-bit counter so the logic stays legal.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [NSLAVES-1:0] hit;
  logic [NSLAVES-1:0] sel_r;
  logic               def_r;
  logic [1:0]         ds;
  logic [XLEN-1:0]    addr_r;
  logic [WDW-1:0]     wd_cnt;
  logic               ua, ua_evt, stall, to_evt;

  for (genvar i = 0; i < NSLAVES; i++) begin : g_dec
    assign hit[i] = (m_haddr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN];
  end

  // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
  assign s_hsel = hit & (~hit + 1'b1);
  assign ua     = ~|hit & m_htrans[1];
  assign ua_evt = m_hready & ua;
  assign stall  = |(sel_r & ~s_hreadyout);
  assign to_evt = (TIMEOUT != 0) && stall && (wd_cnt == WD_LAST);

  // Data-phase response mux: default slave, selected slave, or zero-wait OKAY.
  always_comb begin
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    if (def_r) begin
      m_hready = (ds != DS_ERR1);
      m_hresp  = 1'b1;
    end else begin
      for (int i = 0; i < NSLAVES; i++) begin
        if (sel_r[i]) begin
          m_hready = s_hreadyout[i];
          m_hresp  = s_hresp[i];
          m_hrdata = s_hrdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign s_hready = m_hready;

  // Data-phase ownership and address, captured when an address phase is accepted.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sel_r  <= '0;
      def_r  <= 1'b0;
      addr_r <= '0;
    end else if (m_hready) begin
      sel_r  <= s_hsel;
      def_r  <= ua;
      addr_r <= m_haddr;
    end
  end

  // Default slave: ERR1 (wait, ERROR) then ERR2 (ready, ERROR).
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) ds <= DS_IDLE;
    else begin
      case (ds)
        DS_IDLE: if (ua_evt) ds <= DS_ERR1;
        DS_ERR1: ds <= DS_ERR2;
        DS_ERR2: ds <= ua ? DS_ERR1 : DS_IDLE;
        default: ds <= DS_IDLE;
      endcase
    end
  end

  // Stall watchdog: counts wait cycles of the current transfer, saturating.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) wd_cnt <= '0;
    else if (m_hready) wd_cnt <= '0;
    else if (stall && wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky status: first error wins; a new error beats a simultaneous clear.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_valid <= 1'b0;
      err_cause <= 2'b00;
      err_addr  <= '0;
    end else if ((ua_evt || to_evt) && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_cause <= ua_evt ? 2'b01 : 2'b10;
      err_addr  <= ua_evt ? m_haddr : addr_r;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hasti_bus_n.sv
// Bench for hasti_bus_n: directed protocol scenarios followed by randomized
// pipelined traffic checked against a transaction-level reference model.
module tb_hasti_bus_n;
  logic             hclk = 1'b0;
  logic             hresetn;
  logic [31:0]      m_haddr;
  logic [1:0]       m_htrans;
  logic             m_hready;
  logic [31:0]      m_hrdata;
  logic             m_hresp;
  logic [2:0]       s_hsel;
  logic             s_hready;
  logic [2:0]       sro;
  logic [2:0][31:0] srd;
  logic [2:0]       srs;
  logic             err_clr;
  logic             err_valid;
  logic [1:0]       err_cause;
  logic [31:0]      err_addr;

  int total = 0;
  int bad   = 0;

  hasti_bus_n dut (
    .hclk(hclk), .hresetn(hresetn), .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hready(m_hready), .m_hrdata(m_hrdata), .m_hresp(m_hresp),
    .s_hsel(s_hsel), .s_hready(s_hready), .s_hreadyout(sro), .s_hrdata(srd),
    .s_hresp(srs), .err_clr(err_clr), .err_valid(err_valid),
    .err_cause(err_cause), .err_addr(err_addr)
  );

  always #5 hclk = ~hclk;

  // Address map as written in the block's parameter defaults.
  logic [31:0] base_t [3] = '{32'h0000_0000, 32'h0001_0000, 32'h8000_0000};
  logic [31:0] mask_t [3] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hC000_0000};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & mask_t[i]) == base_t[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int s);
    logic [2:0] v;
    v = 3'b000;
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  // kind: 0 = nothing/IDLE, 1 = mapped NONSEQ, 2 = unmapped NONSEQ
  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          slv;
    int          waits;
    logic [31:0] data;
  } txn_t;

  function automatic txn_t new_txn();
    txn_t t;
    int   r;
    r = $urandom_range(0, 5);
    t.waits = $urandom_range(0, 3);
    t.data  = $urandom;
    case (r)
      0: t.addr = {16'h0000, 16'($urandom)};
      1: t.addr = {16'h0001, 16'($urandom)};
      2: t.addr = {2'b10, 30'($urandom)};
      default: begin
        case ($urandom_range(0, 2))
          0: t.addr = {16'h0002, 16'($urandom)};
          1: t.addr = {2'b01, 30'($urandom)};
          default: t.addr = {2'b11, 30'($urandom)};
        endcase
      end
    endcase
    t.slv  = decode(t.addr);
    t.kind = (r == 5) ? 0 : ((t.slv >= 0) ? 1 : 2);
    return t;
  endfunction

  initial begin
    txn_t        cur, nxt;
    int          cnt, done, cycles;
    logic        mv;
    logic [1:0]  mc;
    logic [31:0] ma;
    logic        e_rdy, e_resp, clr, rbit;
    logic [31:0] e_data;

    hresetn = 1'b0;
    m_htrans = 2'b00; m_haddr = 32'h4000_0000; err_clr = 1'b0;
    sro = 3'b111; srs = 3'b000;
    srd[0] = 32'h1234_5678; srd[1] = 32'hDEAD_BEEF; srd[2] = 32'hCAFE_F00D;
    #2;
    chk("rst_hready", 32'(m_hready), 32'd1);
    chk("rst_hresp", 32'(m_hresp), 32'd0);
    chk("rst_hrdata", m_hrdata, 32'd0);
    chk("rst_s_hready", 32'(s_hready), 32'd1);
    chk("rst_err", {29'd0, err_valid, err_cause}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    cyc(); cyc();
    hresetn = 1'b1;
    cyc();

    // mapped zero-wait read from slave 0
    m_htrans = 2'b10; m_haddr = 32'h0000_0010; #1;
    chk("rd0_hsel", 32'(s_hsel), 32'b001);
    cyc();
    m_htrans = 2'b00; m_haddr = 32'h0002_0000; #1;
    chk("rd0_data", m_hrdata, 32'h1234_5678);
    chk("rd0_rdy_resp", {m_hready, m_hresp}, 32'b10);
    cyc();
    // that IDLE to an unmapped address completes zero-wait OKAY
    #1;
    chk("idle_rsp", {m_hready, m_hresp}, 32'b10);
    chk("idle_data", m_hrdata, 32'd0);
    chk("idle_noerr", 32'(err_valid), 32'd0);

    // unmapped NONSEQ: two-cycle ERROR and status capture
    m_htrans = 2'b10; m_haddr = 32'h0002_0000; #1;
    chk("um_hsel", 32'(s_hsel), 32'b000);
    cyc();
    m_htrans = 2'b00; m_haddr = 32'h4000_0000; #1;
    chk("um_err1", {m_hready, m_hresp}, 32'b01);
    chk("um_err1_data", m_hrdata, 32'd0);
    chk("um_status", {err_valid, err_cause}, 32'b101);
    chk("um_addr", err_addr, 32'h0002_0000);
    cyc(); #1;
    chk("um_err2", {m_hready, m_hresp}, 32'b11);
    cyc(); #1;
    chk("um_after", {m_hready, m_hresp}, 32'b10);
    err_clr = 1'b1; cyc(); err_clr = 1'b0; #1;
    chk("clr", 32'(err_valid), 32'd0);

    // back-to-back unmapped, then a mapped read accepted in ERR2
    m_htrans = 2'b10; m_haddr = 32'h0003_0000; #1;
    cyc();
    m_haddr = 32'h0004_0000; #1;
    chk("b2b_a_err1", {m_hready, m_hresp}, 32'b01);
    cyc(); #1;
    chk("b2b_a_err2", {m_hready, m_hresp}, 32'b11);
    cyc();
    m_haddr = 32'h0001_0004; #1;
    chk("b2b_b_err1", {m_hready, m_hresp}, 32'b01);
    cyc(); #1;
    chk("b2b_b_err2", {m_hready, m_hresp}, 32'b11);
    chk("b2b_hsel", 32'(s_hsel), 32'b010);
    cyc();
    m_htrans = 2'b00; m_haddr = 32'h4000_0000; #1;
    chk("b2b_rd1", m_hrdata, 32'hDEAD_BEEF);
    chk("b2b_rd1_rsp", {m_hready, m_hresp}, 32'b10);
    chk("b2b_first_addr", err_addr, 32'h0003_0000);
    cyc();
    err_clr = 1'b1; cyc(); err_clr = 1'b0; #1;

    // slave 2 stalls 1500 cycles; timeout flagged after exactly 1024
    m_htrans = 2'b10; m_haddr = 32'h8000_0100; #1;
    chk("wd_hsel", 32'(s_hsel), 32'b100);
    cyc();
    m_htrans = 2'b00; m_haddr = 32'h4000_0000; sro[2] = 1'b0;
    for (int k = 1; k <= 1500; k++) begin
      #1;
      chk("wd_stall_rdy", 32'(m_hready), 32'd0);
      cyc();
      chk("wd_valid", 32'(err_valid), (k >= 1024) ? 32'd1 : 32'd0);
    end
    sro[2] = 1'b1; srd[2] = 32'hA5A5_5A5A; #1;
    chk("wd_done", {m_hready, m_hresp}, 32'b10);
    chk("wd_data", m_hrdata, 32'hA5A5_5A5A);
    chk("wd_cause", 32'(err_cause), 32'b10);
    chk("wd_addr", err_addr, 32'h8000_0100);
    cyc();

    // clear and new unmapped error in the same cycle: capture wins
    m_htrans = 2'b10; m_haddr = 32'h0005_0000; err_clr = 1'b1; #1;
    cyc();
    err_clr = 1'b0; m_htrans = 2'b00; m_haddr = 32'h4000_0000; #1;
    chk("clrcap_status", {err_valid, err_cause}, 32'b101);
    chk("clrcap_addr", err_addr, 32'h0005_0000);
    chk("clrcap_err1", {m_hready, m_hresp}, 32'b01);
    // asynchronous reset while in ERR1
    hresetn = 1'b0; #1;
    chk("arst_rsp", {m_hready, m_hresp}, 32'b10);
    chk("arst_valid", 32'(err_valid), 32'd0);
    #2 hresetn = 1'b1;
    cyc();

    // randomized pipelined traffic against a transaction-level model
    cur = '{kind: 0, addr: 32'h0, slv: -1, waits: 0, data: 32'h0};
    nxt = new_txn();
    cnt = 0; done = 0; cycles = 0;
    mv = 1'b0; mc = 2'b00; ma = 32'h0;
    while (done < 400 && cycles < 5000) begin
      cycles++;
      m_htrans = (nxt.kind == 0) ? 2'b00 : 2'b10;
      m_haddr  = nxt.addr;
      clr      = ($urandom_range(0, 7) == 0);
      err_clr  = clr;
      sro = 3'($urandom); srs = 3'($urandom);
      for (int i = 0; i < 3; i++) srd[i] = $urandom;
      rbit = 1'($urandom);
      case (cur.kind)
        1: begin
          e_rdy  = (cnt == cur.waits);
          e_resp = rbit;
          e_data = cur.data;
          sro[cur.slv] = e_rdy;
          srs[cur.slv] = rbit;
          srd[cur.slv] = cur.data;
        end
        2: begin e_rdy = (cnt == 1); e_resp = 1'b1; e_data = 32'h0; end
        default: begin e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'h0; end
      endcase
      #1;
      chk("rnd_hready", 32'(m_hready), 32'(e_rdy));
      chk("rnd_s_hready", 32'(s_hready), 32'(e_rdy));
      chk("rnd_hresp", 32'(m_hresp), 32'(e_resp));
      chk("rnd_hrdata", m_hrdata, e_data);
      chk("rnd_hsel", 32'(s_hsel), 32'(onehot(decode(nxt.addr))));
      if (e_rdy && nxt.kind == 2 && (!mv || clr)) begin
        mv = 1'b1; mc = 2'b01; ma = nxt.addr;
      end else if (clr) begin
        mv = 1'b0;
      end
      cyc();
      chk("rnd_err_valid", 32'(err_valid), 32'(mv));
      chk("rnd_err_cause", 32'(err_cause), 32'(mc));
      chk("rnd_err_addr", err_addr, ma);
      if (e_rdy) begin
        cur = nxt; nxt = new_txn(); cnt = 0; done++;
      end else begin
        cnt++;
      end
    end
    chk("rnd_budget", 32'(done), 32'd400);
    err_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hasti_bus_n.md
Name: hasti_bus_n

Overview:
- Parametrised AHB-Lite (HASTI) interconnect: one master, NSLAVES slaves, address map set by per-slave base/mask parameters.
- Successor to the fixed three-slave bus. Adds:
  - a protocol-correct two-cycle ERROR response from the default slave,
  - a per-transfer stall watchdog,
  - sticky error-capture status for software.
- Sits between the core's HASTI master port and ROM/SRAM/I/O slaves. Address-phase signals (haddr, hwrite, hsize, hburst, hprot, hmastlock, hwdata) are wired straight to the slaves outside this block.

Parameters:
- NSLAVES, 3, number of slaves, 1..16
- XLEN, 32, data and address width
- SLV_BASE, {32'h8000_0000,32'h0001_0000,32'h0000_0000}, packed NSLAVES×XLEN base addresses, index 0 in LSBs
- SLV_MASK, {32'hC000_0000,32'hFFFF_0000,32'hFFFF_0000}, packed NSLAVES×XLEN compare masks; slave i hits when (haddr & MASK[i]) == BASE[i]
- TIMEOUT, 1024, data-phase stall limit in cycles; 0 disables the watchdog

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  reset, asynchronous assert, active-low
- m_haddr  in  XLEN  master address
- m_htrans  in  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- m_hready  out  1  combined HREADY to master
- m_hrdata  out  XLEN  read data to master
- m_hresp  out  1  response to master (0=OKAY, 1=ERROR)
- s_hsel  out  NSLAVES  one-hot slave select, address phase
- s_hready  out  1  HREADY broadcast to all slaves (equals m_hready)
- s_hreadyout  in  NSLAVES  per-slave HREADYOUT
- s_hrdata  in  NSLAVES×XLEN  per-slave read data, packed
- s_hresp  in  NSLAVES  per-slave HRESP
- err_clr  in  1  clears the sticky status
- err_valid  out  1  sticky: error captured
- err_cause  out  2  01=unmapped, 10=timeout
- err_addr  out  XLEN  address of the first captured error

Behaviour:
- Decoder (combinational): hit[i] = (m_haddr & SLV_MASK[i]) == SLV_BASE[i]. On overlapping hits the lowest index wins, and s_hsel is strictly one-hot or zero. s_hsel is driven regardless of htrans.
- Data-phase select register sel_r (one-hot, NSLAVES bits) plus def_r (default slave owns the data phase):
  - Loaded only when m_hready=1.
  - def_r = (no hit) & m_htrans[1].
  - Reset: sel_r=0, def_r=0.
- Mux:
  - sel_r[i] set: m_hrdata/m_hresp/m_hready come from slave i.
  - sel_r=0 and def_r=0: m_hrdata=0, m_hresp=OKAY, m_hready=1, i.e. zero-wait OKAY for IDLE/BUSY.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: when an address phase with no hit and NONSEQ/SEQ is accepted (m_hready=1), go to DS_ERR1.
  - DS_ERR1: m_hready=0, m_hresp=ERROR, m_hrdata=0; next state DS_ERR2.
  - DS_ERR2: m_hready=1, m_hresp=ERROR. A new address phase is accepted here; it goes to DS_ERR1 if it is again unmapped, otherwise to DS_IDLE.
  - Reset state DS_IDLE.
- Watchdog:
  - Counter wd_cnt, width clog2(TIMEOUT+1), is cleared whenever m_hready=1.
  - It increments each cycle that a selected slave holds hreadyout=0, saturating at TIMEOUT.
  - The cycle wd_cnt reaches TIMEOUT, a timeout event fires once per transfer. It is status only; the transfer is not aborted.
- Status:
  - On an unmapped-error entry (DS_IDLE→DS_ERR1) or a timeout event, with err_valid=0: set err_valid=1, and capture err_cause and err_addr. err_addr is the data-phase address, registered from m_haddr when the phase was accepted.
  - Later errors do not overwrite the status while err_valid=1.
  - err_clr=1 clears err_valid. If err_clr and a new error occur in the same cycle, the new error is captured (capture wins).
  - Reset: err_valid=0, err_cause=0, err_addr=0.
- Outputs at reset: m_hready=1, m_hresp=OKAY, m_hrdata=0, s_hready=1.
- An asynchronous reset mid-transfer immediately returns all state to reset values. No pending ERROR is completed.

Test Plan:
- Directed scenarios, using the default parameters:
  - NONSEQ read 0x0000_0010, slave0 returns 0x1234_5678 with zero wait → s_hsel=001, next cycle m_hrdata=0x1234_5678, m_hresp=0, m_hready=1.
  - NONSEQ read 0x0002_0000 (unmapped) → cycle+1: hready=0, hresp=1; cycle+2: hready=1, hresp=1; err_valid=1, err_cause=01, err_addr=0x0002_0000.
  - IDLE to 0x0002_0000 → zero-wait OKAY, err_valid stays 0.
  - Back-to-back unmapped NONSEQ, then a mapped read accepted in DS_ERR2 → two full ERR1/ERR2 pairs, then a normal response; err_addr holds the first address.
  - Slave2 holds hreadyout=0 for 1500 cycles (TIMEOUT=1024) → err_cause=10 at stall cycle 1024, no earlier; m_hready follows the slave; the transfer completes normally at cycle 1500.
  - err_clr pulsed in the same cycle as a new unmapped error → err_valid stays 1 with the new address. hresetn asserted during DS_ERR1 → m_hready=1 and m_hresp=0 immediately.
